// File: rtl/cfi_log_queue.sv
// ============================================================================
// Module   : cfi_log_queue
// Purpose  : Multi-port-in / single-port-out queue of CFI log entries for the
//            CFI checker, with a saturating count of entries lost to overflow.
//            Define CFI_QUEUE_STALL_EN to drive stall_o from free space.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cfi_log_queue_pkg;
    typedef struct packed {
        logic [63:0] addr_pc;
        logic [63:0] target_pc;
        logic [3:0]  cf_type;
    } cfi_log_t;
endpackage

module cfi_log_queue
    import cfi_log_queue_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  cfi_log_t                   log_i [NR_COMMIT_PORTS],
    input  logic [NR_COMMIT_PORTS-1:0] cfi_i,
    input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
    input  logic                       enable_i,
    output logic                       stall_o,
    output logic                       log_valid_o,
    input  logic                       log_ready_i,
    output cfi_log_t                   log_o,
    output logic                       drop_o,
    output logic [CNT_W-1:0]           drop_cnt_o,
    input  logic                       clear_drop_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    logic [PTR_W-1:0]           head_q, head_d;
    logic [PTR_W-1:0]           tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       drop_q;
    logic [CNT_W-1:0]           drop_cnt_q, drop_cnt_d;
    cfi_log_t                   storage_q [DEPTH];

    logic [NR_COMMIT_PORTS-1:0] w_req;
    logic [NR_COMMIT_PORTS-1:0] w_acc;
    logic [PTR_W-1:0]           w_wr_idx [NR_COMMIT_PORTS];
    logic [CW-1:0]              w_free;
    logic [CW-1:0]              w_n_acc;
    logic [CW-1:0]              w_n_drop;
    logic                       w_pop;
    logic [CNT_W:0]             w_drop_sum;

    assign w_req = {NR_COMMIT_PORTS{enable_i}} & commit_ack_i & cfi_i;
    assign w_pop = (count_q != '0) & log_ready_i;

    // Free space comes from registered count only, so a same-cycle pop never
    // makes room for a same-cycle push. Once one request misses, all younger miss.
    always_comb begin
        w_free   = CW'(DEPTH) - count_q;
        w_n_acc  = '0;
        w_n_drop = '0;
        w_acc    = '0;
        for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
            w_wr_idx[i] = tail_q + w_n_acc[PTR_W-1:0];
            if (w_req[i]) begin
                if (w_n_acc < w_free) begin
                    w_acc[i] = 1'b1;
                    w_n_acc  = w_n_acc + CW'(1);
                end else begin
                    w_n_drop = w_n_drop + CW'(1);
                end
            end
        end
    end

    always_comb begin
        head_d     = head_q + PTR_W'(w_pop);
        tail_d     = tail_q + w_n_acc[PTR_W-1:0];
        count_d    = count_q + w_n_acc - CW'(w_pop);
        w_drop_sum = (clear_drop_i ? {(CNT_W+1){1'b0}} : {1'b0, drop_cnt_q})
                   + (CNT_W+1)'(w_n_drop);
        drop_cnt_d = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            drop_q     <= (w_n_drop != '0);
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (w_acc[i]) begin
                storage_q[w_wr_idx[i]] <= log_i[i];
            end
        end
    end

    assign log_valid_o = (count_q != '0);
    assign log_o       = storage_q[head_q];
    assign drop_o      = drop_q;
    assign drop_cnt_o  = drop_cnt_q;

`ifdef CFI_QUEUE_STALL_EN
    assign stall_o = (w_free < CW'(NR_COMMIT_PORTS));
`else
    assign stall_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cfi_log_queue.sv
// Directed bench for cfi_log_queue; a negedge monitor checks every popped
// entry against an expected-entry queue filled by the stimulus.
`default_nettype none

module tb_cfi_log_queue;
    import cfi_log_queue_pkg::*;

    localparam int NP    = 2;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
`ifdef CFI_QUEUE_STALL_EN
    localparam logic STALL_EN = 1'b1;
`else
    localparam logic STALL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_ni;
    cfi_log_t         log_i [NP];
    logic [NP-1:0]    cfi_i;
    logic [NP-1:0]    commit_ack_i;
    logic             enable_i;
    logic             stall_o;
    logic             log_valid_o;
    logic             log_ready_i;
    cfi_log_t         log_o;
    logic             drop_o;
    logic [CNT_W-1:0] drop_cnt_o;
    logic             clear_drop_i;

    always #5 clk = ~clk;

    cfi_log_queue #(
        .NR_COMMIT_PORTS(NP),
        .DEPTH          (DEPTH),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .log_i       (log_i),
        .cfi_i       (cfi_i),
        .commit_ack_i(commit_ack_i),
        .enable_i    (enable_i),
        .stall_o     (stall_o),
        .log_valid_o (log_valid_o),
        .log_ready_i (log_ready_i),
        .log_o       (log_o),
        .drop_o      (drop_o),
        .drop_cnt_o  (drop_cnt_o),
        .clear_drop_i(clear_drop_i)
    );

    cfi_log_t exp_q [$];
    int       total = 0;
    int       bad   = 0;
    cfi_log_t held_val;
    bit       held  = 1'b0;

    function automatic cfi_log_t mk(input logic [63:0] pc);
        cfi_log_t r;
        r.addr_pc   = pc;
        r.target_pc = pc ^ 64'h0000_0000_0000_F000;
        r.cf_type   = pc[5:2];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name, input cfi_log_t act, input cfi_log_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got pc=%0h entry=%h want pc=%0h entry=%h",
                     name, act.addr_pc, act, exp.addr_pc, exp);
        end
    endtask

    // Monitor: compares each accepted head against the scoreboard and checks
    // the head stays stable while back-pressured.
    always @(negedge clk) begin
        if (rst_ni && log_valid_o) begin
            if (!log_ready_i) begin
                if (held) check_log("stable", log_o, held_val);
                held     = 1'b1;
                held_val = log_o;
            end else begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got pc=%0h want no entry", log_o.addr_pc);
                end else begin
                    check_log("pop", log_o, exp_q.pop_front());
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic drive(input logic [1:0] c, input logic [1:0] a,
                         input logic [63:0] p0, input logic [63:0] p1);
        cfi_i        = c;
        commit_ack_i = a;
        log_i[0]     = mk(p0);
        log_i[1]     = mk(p1);
        @(posedge clk);
        #1;
        cfi_i        = '0;
        commit_ack_i = '0;
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni       = 1'b0;
        enable_i     = 1'b1;
        log_ready_i  = 1'b1;
        clear_drop_i = 1'b0;
        cfi_i        = '0;
        commit_ack_i = '0;
        log_i[0]     = mk(64'h0);
        log_i[1]     = mk(64'h0);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(log_valid_o), 64'h0);
        check("rst_drop", 64'(drop_o), 64'h0);
        check("rst_cnt", 64'(drop_cnt_o), 64'h0);
        check("rst_stall", 64'(stall_o), 64'h0);
        realign();
        rst_ni = 1'b1;

        // single push on port 0, one-cycle latency, then empty
        exp_q.push_back(mk(64'h40));
        drive(2'b01, 2'b01, 64'h40, 64'h44);
        @(negedge clk);
        check("t1_valid", 64'(log_valid_o), 64'h1);
        @(negedge clk);
        check("t1_empty", 64'(log_valid_o), 64'h0);
        realign();

        // dual push held by back-pressure, then drained in order
        log_ready_i = 1'b0;
        exp_q.push_back(mk(64'h100));
        exp_q.push_back(mk(64'h104));
        drive(2'b11, 2'b11, 64'h100, 64'h104);
        repeat (3) realign();
        @(negedge clk);
        check("t2_head", log_o.addr_pc, 64'h100);
        realign();
        log_ready_i = 1'b1;
        repeat (3) realign();
        @(negedge clk);
        check("t2_empty", 64'(log_valid_o), 64'h0);
        realign();

        // port 1 only, then enable low blocks pushes
        exp_q.push_back(mk(64'h204));
        drive(2'b10, 2'b11, 64'h200, 64'h204);
        enable_i = 1'b0;
        drive(2'b11, 2'b11, 64'h300, 64'h304);
        enable_i = 1'b1;
        repeat (3) realign();
        @(negedge clk);
        check("t3_empty", 64'(log_valid_o), 64'h0);
        check("t3_cnt", 64'(drop_cnt_o), 64'h0);
        realign();

        // fill to 7, then partial overflow, then full overflow
        log_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(64'h400 + 64'(8 * k)));
            exp_q.push_back(mk(64'h404 + 64'(8 * k)));
            drive(2'b11, 2'b11, 64'h400 + 64'(8 * k), 64'h404 + 64'(8 * k));
        end
        exp_q.push_back(mk(64'h418));
        drive(2'b01, 2'b01, 64'h418, 64'h0);
        @(negedge clk);
        check("t4_stall7", 64'(stall_o), 64'(STALL_EN));
        check("t4_nodrop", 64'(drop_o), 64'h0);
        realign();
        exp_q.push_back(mk(64'h41c));
        drive(2'b11, 2'b11, 64'h41c, 64'h420);
        @(negedge clk);
        check("t4_drop1", 64'(drop_o), 64'h1);
        check("t4_cnt1", 64'(drop_cnt_o), 64'h1);
        realign();
        drive(2'b11, 2'b11, 64'h500, 64'h504);
        @(negedge clk);
        check("t4_drop2", 64'(drop_o), 64'h1);
        check("t4_cnt3", 64'(drop_cnt_o), 64'h3);
        check("t4_stall8", 64'(stall_o), 64'(STALL_EN));
        realign();
        @(negedge clk);
        check("t4_pulse", 64'(drop_o), 64'h0);
        realign();

        // saturation of the drop counter, then clear with one drop
        cfi_i        = 2'b11;
        commit_ack_i = 2'b11;
        repeat (32768) @(posedge clk);
        #1;
        cfi_i        = '0;
        commit_ack_i = '0;
        @(negedge clk);
        check("t5_sat", 64'(drop_cnt_o), 64'hFFFF);
        realign();
        drive(2'b11, 2'b11, 64'h800, 64'h804);
        @(negedge clk);
        check("t5_sat_hold", 64'(drop_cnt_o), 64'hFFFF);
        realign();
        clear_drop_i = 1'b1;
        drive(2'b01, 2'b01, 64'h900, 64'h0);
        clear_drop_i = 1'b0;
        @(negedge clk);
        check("t5_clear", 64'(drop_cnt_o), 64'h1);
        realign();
        log_ready_i = 1'b1;
        repeat (10) realign();
        @(negedge clk);
        check("t5_drained", 64'(log_valid_o), 64'h0);
        realign();

        // reset with five entries queued
        log_ready_i = 1'b0;
        exp_q.push_back(mk(64'h600));
        exp_q.push_back(mk(64'h604));
        drive(2'b11, 2'b11, 64'h600, 64'h604);
        exp_q.push_back(mk(64'h608));
        exp_q.push_back(mk(64'h60c));
        drive(2'b11, 2'b11, 64'h608, 64'h60c);
        exp_q.push_back(mk(64'h610));
        drive(2'b01, 2'b01, 64'h610, 64'h0);
        @(negedge clk);
        check("t6_pre", 64'(log_valid_o), 64'h1);
        realign();
        rst_ni = 1'b0;
        realign();
        rst_ni = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t6_valid", 64'(log_valid_o), 64'h0);
        check("t6_cnt", 64'(drop_cnt_o), 64'h0);
        check("t6_stall", 64'(stall_o), 64'h0);
        realign();
        log_ready_i = 1'b1;
        exp_q.push_back(mk(64'h700));
        drive(2'b01, 2'b01, 64'h700, 64'h0);
        @(negedge clk);
        check("t6_post", 64'(log_valid_o), 64'h1);
        repeat (3) realign();
        check("drain_all", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
